fetch_unit_pf: RTL
==================

Name: fetch_unit_pf

Overview:
Parametrised next-generation instruction fetch unit with an in-order prefetch queue. It issues sequential PC requests to instruction memory over a valid/ready handshake, tolerating multi-cycle memory latency. It buffers returned instructions in a DEPTH-entry FIFO with their PCs, and handles branch redirects (pc_sel, branch_pc + imm) by flushing the queue and discarding in-flight responses. It sits between the imem port and the decode stage.

Parameters:
XLEN, 32, address/instruction width in bits
DEPTH, 4, prefetch FIFO entries and maximum in-flight requests; power of two, >= 2
RESET_PC, 32'h00000000, first fetch address after reset; bits [1:0] must be 0

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
pc_sel  input  1  redirect strobe, one cycle per redirect
branch_pc  input  XLEN  PC of redirecting instruction
imm  input  XLEN  signed offset; target = branch_pc + imm
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address
imem_rsp_valid  input  1  response valid; in order, one per accepted request, never back-pressured
imem_rsp_data  input  XLEN  instruction word
inst_valid  output  1  head of queue valid
inst_ready  input  1  decode accepts head
inst  output  XLEN  instruction at head
inst_pc  output  XLEN  PC of head instruction

Behaviour:
- Reset (async assert): fetch_pc = rsp_pc = RESET_PC. FIFO count, outstanding, and discard all 0. inst_valid = 0, inst = 0, inst_pc = 0, imem_req_addr = RESET_PC, imem_req_valid = 0.
- First request asserts in the first cycle after reset deasserts.
- Issue: imem_req_valid = !pc_sel && (count + outstanding < DEPTH). imem_req_addr = fetch_pc. Addr is held stable while valid and not ready.
- On a request handshake: fetch_pc += 4 (wraps mod 2^XLEN), outstanding++.
- Response: every imem_rsp_valid decrements outstanding.
  - If discard > 0: data dropped, discard--.
  - Otherwise push {imem_rsp_data, rsp_pc} into the FIFO and set rsp_pc += 4.
- Latency: a response accepted at edge N gives inst_valid = 1 after edge N (visible in cycle N+1). No combinational rsp-to-inst path.
- Output: inst_valid = (count != 0). inst and inst_pc show the head entry and are registered/stable while inst_valid && !inst_ready. Pop on inst_valid && inst_ready.
- Push and pop in the same cycle: count unchanged. Overflow is impossible because count + outstanding <= DEPTH is invariant.
- Redirect (pc_sel = 1) at edge N:
  - target = (branch_pc + imm) with bits [1:0] forced to 0; wraps mod 2^XLEN.
  - fetch_pc = rsp_pc = target, FIFO cleared (count = 0).
  - discard = outstanding - (imem_rsp_valid ? 1 : 0), i.e. every still-in-flight response is dropped. Any response arriving in cycle N is dropped.
  - imem_req_valid is forced 0 in cycle N. This is the only permitted withdrawal of an un-acked request; the memory must not sample addr when valid is low.
  - A pop handshake in cycle N is legal (decode consumed it). inst_valid = 0 in cycle N+1. The first request to target issues in cycle N+1.
- Redirect while discard > 0: the new discard overwrites the old. It is correct because outstanding counts all in-flight requests.
- Back-to-back redirects: the last one wins. No request is issued between them.
- Reset mid-operation: all state returns to reset values immediately. Memory responses to pre-reset requests are the memory's responsibility; the memory must also be reset.
- Misaligned branch_pc + imm: silently aligned to 4 bytes, no exception.

Optional Feature:
FETCH_STATS_EN:
- Defined: adds outputs stat_fetched[31:0] and stat_flushed[31:0], both reset to 0 and wrapping.
  - stat_fetched counts FIFO pops (inst handshakes).
  - stat_flushed counts entries cleared from the FIFO plus responses dropped via discard.
- Undefined: ports and counters are absent. Core behaviour is identical.

Test Plan:
- Reset with RESET_PC = 0, ready = 1, 1-cycle memory, inst_ready = 1 -> inst_pc sequence 0x0, 0x4, 0x8, 0xC; one instruction per cycle after the first.
- inst_ready = 0 with memory always ready -> exactly 4 requests issued (0x0 to 0xC), then imem_req_valid = 0. Raising inst_ready drains 0x0 to 0xC in order and fetching resumes at 0x10.
- 3-cycle memory latency, 2 requests in flight, pc_sel with branch_pc = 0x8, imm = 0x2 -> target 0x8 (0xA aligned). Next request addr = 0x8, both stale responses dropped, first inst_pc = 0x8.
- pc_sel in the same cycle as imem_rsp_valid and an inst pop -> pop honoured, response dropped, discard = outstanding - 1, no stale inst_pc appears afterwards.
- branch_pc = 0xFFFFFFFC, imm = 0x4 -> fetch wraps to 0x0. Also assert reset mid-stream -> inst_valid = 0 immediately, fetch restarts at RESET_PC.
- FETCH_STATS_EN defined: 5 pops, then a redirect with 3 queued and 1 in flight -> stat_fetched = 5, stat_flushed = 4.

Source files
------------

// File: rtl/fetch_unit_pf.sv
// Instruction fetch unit with an in-order DEPTH-entry prefetch queue and branch redirect.
// Optional FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module fetch_unit_pf #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] imm,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     stat_fetched,
  output logic [31:0]     stat_flushed
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0]            fetch_pc, rsp_pc;
  logic [CW-1:0]              count, outstanding, discard;
  logic [AW-1:0]              rd_ptr, wr_ptr;
  logic [DEPTH-1:0][XLEN-1:0] q_inst, q_pc;

  logic [CW:0]     occ;
  logic [XLEN-1:0] target_raw, target;
  logic            req_fire, pop, rsp_drop, push;

  // Requests are only issued while a queue slot is reserved for the response,
  // so count + outstanding never exceeds DEPTH.
  assign occ            = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = reset && !pc_sel && (occ < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = (count != '0);
  assign inst       = q_inst[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];
  assign pop        = inst_valid && inst_ready;

  assign rsp_drop = imem_rsp_valid && (pc_sel || discard != '0);
  assign push     = imem_rsp_valid && !rsp_drop;

  assign target_raw = branch_pc + imm;
  assign target     = {target_raw[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      q_inst      <= '0;
      q_pc        <= '0;
    end else if (pc_sel) begin
      // Every request still in flight after this edge must be dropped on return.
      fetch_pc    <= target;
      rsp_pc      <= target;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      discard     <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (rsp_drop) discard <= discard - CW'(1);
      if (push) begin
        q_inst[wr_ptr] <= imem_rsp_data;
        q_pc[wr_ptr]   <= rsp_pc;
        wr_ptr         <= wr_ptr + AW'(1);
        rsp_pc         <= rsp_pc + XLEN'(4);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef FETCH_STATS_EN
  // A pop in the redirect cycle counts as fetched, not flushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (pop) stat_fetched <= stat_fetched + 32'd1;
      if (pc_sel)
        stat_flushed <= stat_flushed + 32'(count) - 32'(pop) + 32'(imem_rsp_valid);
      else if (rsp_drop)
        stat_flushed <= stat_flushed + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
